// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the RV32I-subset multi-cycle sequencer.
`default_nettype none

package core_sequencer_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        FETCH      = 3'd0,
        WAIT_RDATA = 3'd1,
        EXECUTE    = 3'd2,
        SLEEP      = 3'd3,
        HALT       = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        WbAlu   = 2'd0,
        WbImm   = 2'd1,
        WbPcImm = 2'd2,
        WbLink  = 2'd3
    } wb_sel_e;

    localparam word_t WfiInstr = 32'h1050_0073;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcArithI = 7'b0010011;
    localparam logic [6:0] OpcArithR = 7'b0110011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

endpackage

`default_nettype wire

// File: rtl/next_pc_unit.sv
// Combinational next-PC selection: jal, jalr (LSB cleared) or sequential pc+4.
`default_nettype none

module next_pc_unit
    import core_sequencer_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_i,
    input  logic [6:0]  opcode_i,
    output logic [31:0] target_o
);

    logic [31:0] w_jalr_sum;

    assign w_jalr_sum = rs1_i + imm_i;

    always_comb begin
        target_o = pc_i + 32'd4;
        if (opcode_i == OpcJal) begin
            target_o = pc_i + imm_i;
        end else if (opcode_i == OpcJalr) begin
            target_o = w_jalr_sum & ~32'h1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_sequencer.sv
// Multi-cycle control unit: fetch handshake, decode, PC update, wfi sleep and illegal halt.
`default_nettype none

module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [31:0] ResetPc = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_data_i,
    input  logic        irq_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        rf_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        alu_src_o,
    output logic        retire_o,
    output logic        sleeping_o,
    output logic        illegal_o
);

    seq_state_e  state_q;
    word_t       pc_q;
    word_t       pc_d;
    word_t       instr_q;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic        w_is_wfi;
    logic        w_legal;
    logic        w_writes;
    logic        w_alu_src;
    wb_sel_e     w_wb_sel;
    logic        w_exec;

    assign w_opcode = instr_q[6:0];
    assign w_rd     = instr_q[11:7];
    assign w_funct3 = instr_q[14:12];
    assign w_funct7 = instr_q[31:25];
    assign w_is_wfi = (instr_q == WfiInstr);
    assign w_exec   = (state_q == EXECUTE);

    always_comb begin
        w_legal   = 1'b0;
        w_writes  = 1'b0;
        w_alu_src = 1'b0;
        w_wb_sel  = WbAlu;
        case (w_opcode)
            OpcLui:    begin w_legal = 1'b1; w_writes = 1'b1; w_wb_sel = WbImm;   end
            OpcAuipc:  begin w_legal = 1'b1; w_writes = 1'b1; w_wb_sel = WbPcImm; end
            OpcJal:    begin w_legal = 1'b1; w_writes = 1'b1; w_wb_sel = WbLink;  end
            OpcArithI: begin
                if (w_funct3 == 3'b000) begin
                    w_legal   = 1'b1;
                    w_writes  = 1'b1;
                    w_alu_src = 1'b1;
                end
            end
            OpcArithR: begin
                if (w_funct3 == 3'b000 && w_funct7 == 7'b0) begin
                    w_legal  = 1'b1;
                    w_writes = 1'b1;
                end
            end
            OpcJalr: begin
                if (w_funct3 == 3'b000) begin
                    w_legal  = 1'b1;
                    w_writes = 1'b1;
                    w_wb_sel = WbLink;
                end
            end
            default: begin
                w_legal = w_is_wfi;
            end
        endcase
    end

    next_pc_unit u_next_pc (
        .pc_i     (pc_q),
        .imm_i    (imm_i),
        .rs1_i    (rs1_data_i),
        .opcode_i (w_opcode),
        .target_o (pc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= ResetPc;
            instr_q <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_gnt_i) state_q <= WAIT_RDATA;
                end
                WAIT_RDATA: begin
                    if (imem_rvalid_i) begin
                        instr_q <= imem_rdata_i;
                        state_q <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (w_legal) begin
                        pc_q    <= pc_d;
                        state_q <= w_is_wfi ? SLEEP : FETCH;
                    end else begin
                        state_q <= HALT;
                    end
                end
                SLEEP: begin
                    if (irq_i) state_q <= FETCH;
                end
                HALT:    state_q <= HALT;
                default: state_q <= FETCH;
            endcase
        end
    end

    // Request is gated by rst_n so it stays low while reset is held, then rises right after release.
    assign imem_req_o  = rst_n && (state_q == FETCH);
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign instr_o     = instr_q;
    assign rf_we_o     = w_exec && w_writes && (w_rd != 5'd0);
    assign retire_o    = w_exec && w_legal;
    assign wb_sel_o    = w_exec ? w_wb_sel : WbAlu;
    assign alu_src_o   = w_exec && w_alu_src;
    assign sleeping_o  = (state_q == SLEEP);
    assign illegal_o   = (state_q == HALT);

endmodule

`default_nettype wire

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer.
`default_nettype none

module tb_core_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        irq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        alu_src;
    logic        retire;
    logic        sleeping;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    core_sequencer #(.ResetPc(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .imm_i         (imm),
        .rs1_data_i    (rs1_data),
        .irq_i         (irq),
        .pc_o          (pc),
        .instr_o       (instr),
        .rf_we_o       (rf_we),
        .wb_sel_o      (wb_sel),
        .alu_src_o     (alu_src),
        .retire_o      (retire),
        .sleeping_o    (sleeping),
        .illegal_o     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Starts in FETCH; leaves the DUT in EXECUTE of the given instruction.
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] im, input logic [31:0] rs1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = ins;
        imm         = im;
        rs1_data    = rs1;
        tick();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        imm = '0; rs1_data = '0; irq = 1'b0;
        tick(); tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_outs", {24'd0, rf_we, wb_sel, alu_src, retire, sleeping, illegal, 1'b0}, 32'd0);

        // addi x1,x0,5
        rst_n = 1'b1;
        #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        run_instr(32'h0050_0093, 32'd5, 32'd0);
        chk("addi_instr", instr, 32'h0050_0093);
        chk("addi_ctl", {28'd0, retire, rf_we, wb_sel}, {28'd0, 1'b1, 1'b1, 2'd0});
        chk("addi_alusrc", {31'd0, alu_src}, 32'd1);
        tick();
        chk("addi_pc", pc, 32'h4);
        chk("addi_next_addr", imem_addr, 32'h4);

        // grant back-pressure
        for (int i = 0; i < 4; i++) begin
            chk("bp_req", {31'd0, imem_req}, 32'd1);
            chk("bp_addr", imem_addr, 32'h4);
            chk("bp_noretire", {31'd0, retire}, 32'd0);
            tick();
        end
        // add x2,x1,x1
        run_instr(32'h0010_8133, 32'd0, 32'd0);
        chk("add_ctl", {27'd0, retire, rf_we, alu_src, wb_sel}, {27'd0, 1'b1, 1'b1, 1'b0, 2'd0});
        tick();
        chk("add_retire_once", {31'd0, retire}, 32'd0);

        // lui x3,0x12345 at 0x8
        run_instr(32'h1234_51B7, 32'h1234_5000, 32'd0);
        chk("lui_ctl", {29'd0, rf_we, wb_sel}, {29'd0, 1'b1, 2'd1});
        tick();
        // auipc x4,0 at 0xC
        run_instr(32'h0000_0217, 32'd0, 32'd0);
        chk("auipc_ctl", {29'd0, rf_we, wb_sel}, {29'd0, 1'b1, 2'd2});
        tick();
        chk("auipc_next", imem_addr, 32'h10);

        // jal x1,+8 at 0x10
        run_instr(32'h0080_00EF, 32'd8, 32'd0);
        chk("jal_ctl", {28'd0, retire, rf_we, wb_sel}, {28'd0, 1'b1, 1'b1, 2'd3});
        tick();
        chk("jal_target", imem_addr, 32'h18);

        // jalr x0,x5,3 with x5=0x100
        run_instr(32'h0032_8067, 32'd3, 32'h100);
        chk("jalr_ctl", {28'd0, retire, rf_we, wb_sel}, {28'd0, 1'b1, 1'b0, 2'd3});
        tick();
        chk("jalr_target", imem_addr, 32'h102);

        // jalr x0,x5,0 with x5=0x20, then wfi with irq low
        run_instr(32'h0002_8067, 32'd0, 32'h20);
        tick();
        chk("to_wfi_addr", imem_addr, 32'h20);
        run_instr(32'h1050_0073, 32'd0, 32'd0);
        chk("wfi_retire", {30'd0, retire, rf_we}, {30'd0, 1'b1, 1'b0});
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("sleep_flag", {31'd0, sleeping}, 32'd1);
            chk("sleep_noreq", {31'd0, imem_req}, 32'd0);
            if (i < 4) tick();
        end
        irq = 1'b1;
        tick();
        irq = 1'b0;
        chk("wake_sleep", {31'd0, sleeping}, 32'd0);
        chk("wake_req", {31'd0, imem_req}, 32'd1);
        chk("wake_addr", imem_addr, 32'h24);

        // wfi with irq already high: one-cycle SLEEP
        run_instr(32'h1050_0073, 32'd0, 32'd0);
        irq = 1'b1;
        tick();
        chk("short_sleep", {31'd0, sleeping}, 32'd1);
        tick();
        irq = 1'b0;
        chk("short_wake", {30'd0, sleeping, imem_req}, {30'd0, 1'b0, 1'b1});
        chk("short_addr", imem_addr, 32'h28);

        // PC wrap
        run_instr(32'h0002_8067, 32'd0, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
        run_instr(32'h0010_0093, 32'd1, 32'd0);
        tick();
        chk("wrap_addr", imem_addr, 32'h0);

        // illegal: R-type funct3=001
        run_instr(32'h0000_1033, 32'd0, 32'd0);
        chk("ill_exec", {29'd0, retire, rf_we, illegal}, 32'd0);
        tick();
        chk("ill_halt", {30'd0, illegal, imem_req}, {30'd0, 1'b1, 1'b0});
        chk("ill_pc", pc, 32'h0);
        imem_gnt = 1'b1;
        tick(); tick();
        imem_gnt = 1'b0;
        chk("ill_absorb", {30'd0, illegal, imem_req}, {30'd0, 1'b1, 1'b0});
        rst_n = 1'b0;
        #1;
        chk("ill_rst", {31'd0, illegal}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("ill_refetch", {31'd0, imem_req}, 32'd1);
        chk("ill_refetch_addr", imem_addr, 32'h0);

        // async reset with a grant outstanding
        run_instr(32'h0050_0093, 32'd5, 32'd0);
        tick();
        chk("ar_pre_pc", pc, 32'h4);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("ar_in_wait", {31'd0, imem_req}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_pc", pc, 32'h0);
        chk("ar_instr", instr, 32'h0);
        chk("ar_req", {31'd0, imem_req}, 32'd0);
        tick();
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        chk("stale_instr", instr, 32'h0);
        chk("stale_state", {30'd0, imem_req, retire}, {30'd0, 1'b1, 1'b0});
        chk("stale_addr", imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
